// File: rtl/decoder_hex_16_sched_if.sv
// rtl/decoder_hex_16_sched_if.sv - requester, decoder and display signal bundle for decoder_hex_16_sched
//
// Purpose: groups every non-clock/reset signal of the scheduler.
// Signals:
//   req        per-channel level request (requesters -> scheduler)
//   val        4-bit value per channel, channel i on val[4i+3:4i]
//   ack        one-cycle per-channel "published" pulse (scheduler -> requesters)
//   dec_x      registered drive to the shared decoder input
//   dec_h0/h1  decoder ones/tens digit, segment a..g, 1 = lit
//   disp_h0/h1 registered digits for the display driver
//   disp_ch    channel whose result is currently shown
//   disp_valid one-cycle pulse when disp_* update
//   busy       scheduler is servicing a channel
// Modports: master = environment side, slave = scheduler side.

interface decoder_hex_16_sched_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0]   req;
    logic [4*N_CH-1:0] val;
    logic [N_CH-1:0]   ack;
    logic [3:0]        dec_x;
    logic [0:6]        dec_h0;
    logic [0:6]        dec_h1;
    logic [0:6]        disp_h0;
    logic [0:6]        disp_h1;
    logic [2:0]        disp_ch;
    logic              disp_valid;
    logic              busy;

    modport master (
        output req, val, dec_h0, dec_h1,
        input  ack, dec_x, disp_h0, disp_h1, disp_ch, disp_valid, busy
    );

    modport slave (
        input  req, val, dec_h0, dec_h1,
        output ack, dec_x, disp_h0, disp_h1, disp_ch, disp_valid, busy
    );
endinterface

// File: rtl/decoder_hex_16_sched.sv
// rtl/decoder_hex_16_sched.sv - round-robin scheduler sharing one hex-to-7seg decoder among N_CH requesters
//
// Purpose: grants one requesting channel at a time, drives its value to the
// external decoder, publishes the two decoded digits with the channel tag and
// an ack pulse, then holds for HOLD_CYC cycles before the next grant.
// Ports:
//   clk   system clock, rising edge
//   rst_n asynchronous active-low reset
//   bus   decoder_hex_16_sched_if.slave (req/val/ack, dec_*, disp_*, busy)

module decoder_hex_16_sched #(
    parameter int N_CH     = 4,
    parameter int HOLD_CYC = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    decoder_hex_16_sched_if.slave  bus
);

    localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_SAMPLE,
        S_HOLD
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [2:0]       grant_q, grant_d;
    logic [3:0]       dec_x_q, dec_x_d;
    logic [0:6]       disp_h0_q, disp_h0_d;
    logic [0:6]       disp_h1_q, disp_h1_d;
    logic [2:0]       disp_ch_q, disp_ch_d;
    logic             disp_valid_q, disp_valid_d;
    logic [N_CH-1:0]  ack_q, ack_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Requests/values widened to the 8-channel maximum so a 3-bit index
    // can address them for any legal N_CH; absent channels read as zero.
    logic [7:0]       req_pad;
    logic [31:0]      val_pad;
    logic [7:0]       ack_onehot;
    logic [3:0]       cand;
    logic             pick_found;
    logic [2:0]       pick_idx;

    always_comb begin
        req_pad = '0;
        req_pad[N_CH-1:0] = bus.req;
        val_pad = '0;
        val_pad[4*N_CH-1:0] = bus.val;
    end

    // Round-robin search starting at ptr. Walking the offsets from the far
    // end back to zero lets the nearest requester overwrite any later one.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = ptr_q;
        cand       = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_q} + 4'(k);
            if (cand >= 4'(N_CH)) begin
                cand = cand - 4'(N_CH);
            end
            if (req_pad[cand[2:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[2:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            grant_q      <= '0;
            dec_x_q      <= '0;
            disp_h0_q    <= '0;
            disp_h1_q    <= '0;
            disp_ch_q    <= '0;
            disp_valid_q <= 1'b0;
            ack_q        <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            grant_q      <= grant_d;
            dec_x_q      <= dec_x_d;
            disp_h0_q    <= disp_h0_d;
            disp_h1_q    <= disp_h1_d;
            disp_ch_q    <= disp_ch_d;
            disp_valid_q <= disp_valid_d;
            ack_q        <= ack_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        grant_d      = grant_q;
        dec_x_d      = dec_x_q;
        disp_h0_d    = disp_h0_q;
        disp_h1_d    = disp_h1_q;
        disp_ch_d    = disp_ch_q;
        disp_valid_d = 1'b0;
        ack_d        = '0;
        cnt_d        = cnt_q;
        ack_onehot   = 8'd1 << grant_q;

        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    // Value is captured only here; later val/req changes
                    // cannot disturb the service in progress.
                    dec_x_d = val_pad[{pick_idx, 2'b00} +: 4];
                    grant_d = pick_idx;
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                // Settle cycle for the combinational decoder.
                state_d = S_SAMPLE;
            end
            S_SAMPLE: begin
                disp_h0_d    = bus.dec_h0;
                disp_h1_d    = bus.dec_h1;
                disp_ch_d    = grant_q;
                disp_valid_d = 1'b1;
                ack_d        = ack_onehot[N_CH-1:0];
                ptr_d        = (grant_q == 3'(N_CH - 1)) ? 3'd0 : grant_q + 3'd1;
                cnt_d        = CNT_W'(HOLD_CYC - 1);
                state_d      = S_HOLD;
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.dec_x      = dec_x_q;
    assign bus.disp_h0    = disp_h0_q;
    assign bus.disp_h1    = disp_h1_q;
    assign bus.disp_ch    = disp_ch_q;
    assign bus.disp_valid = disp_valid_q;
    assign bus.ack        = ack_q;
    assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_decoder_hex_16_sched.sv
// tb/tb_decoder_hex_16_sched.sv - self-checking bench for decoder_hex_16_sched

module tb_decoder_hex_16_sched;

    localparam int N    = 4;
    localparam int HOLD = 16;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   vcyc   = 0;
    int   m_ptr  = 0;
    bit   mon_en = 0;

    decoder_hex_16_sched_if #(.N_CH(N)) bus();

    decoder_hex_16_sched #(.N_CH(N), .HOLD_CYC(HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // 7-segment digit patterns, written g..a from left to right.
    function automatic logic [6:0] seg7(input int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    // Shared decoder: decimal tens and ones of the 4-bit input.
    assign bus.dec_h0 = seg7(int'(bus.dec_x) % 10);
    assign bus.dec_h1 = seg7(int'(bus.dec_x) / 10);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference arbitration: first requesting channel at or above p, modulo N.
    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        int c;
        for (int k = 0; k < N; k++) begin
            c = (p + k) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (bus.disp_valid) chk("ack_onehot", 32'($onehot(bus.ack)), 1);
            else                chk("ack_idle", 32'(bus.ack), 0);
        end
    end

    // Called at a negedge with req/val already set; the next posedge is the
    // grant edge. ra/va are applied one cycle after the grant. Returns at the
    // negedge where busy has dropped.
    task automatic run_service(input logic [N-1:0] ra, input logic [4*N-1:0] va,
                               output int och, output logic [6:0] oh0, output logic [6:0] oh1);
        int exp_ch;
        int exp_x;
        int bcnt;
        int guard;
        och = -1; oh0 = '0; oh1 = '0;
        exp_ch = rr_pick(bus.req, m_ptr);
        if (exp_ch < 0) begin
            chk("no_request", 0, 1);
            return;
        end
        exp_x = int'((bus.val >> (4 * exp_ch)) & 16'hF);
        @(posedge clk);
        @(negedge clk);
        chk("dec_x", 32'(bus.dec_x), exp_x);
        chk("busy_after_grant", 32'(bus.busy), 1);
        bcnt = 1;
        bus.req = ra;
        bus.val = va;
        @(negedge clk);
        if (bus.busy) bcnt++;
        chk("valid_early", 32'(bus.disp_valid), 0);
        @(negedge clk);
        if (bus.busy) bcnt++;
        vcyc = cyc;
        chk("disp_valid", 32'(bus.disp_valid), 1);
        chk("ack", 32'(bus.ack), 32'(1 << exp_ch));
        chk("disp_ch", 32'(bus.disp_ch), exp_ch);
        chk("disp_h0", 32'(bus.disp_h0), 32'(seg7(exp_x % 10)));
        chk("disp_h1", 32'(bus.disp_h1), 32'(seg7(exp_x / 10)));
        och = int'(bus.disp_ch);
        oh0 = bus.disp_h0;
        oh1 = bus.disp_h1;
        m_ptr = (exp_ch + 1) % N;
        @(negedge clk);
        if (bus.busy) bcnt++;
        chk("valid_single", 32'(bus.disp_valid), 0);
        chk("ack_single", 32'(bus.ack), 0);
        guard = 0;
        @(negedge clk);
        while (bus.busy && guard < 100) begin
            bcnt++;
            guard++;
            @(negedge clk);
        end
        // Busy covers DRIVE, SAMPLE and HOLD_CYC hold cycles.
        chk("busy_len", bcnt, HOLD + 2);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;
    endtask

    initial begin
        int          och;
        logic [6:0]  oh0, oh1;
        int          prev;
        int          rr_exp[5];

        rst_n   = 1'b0;
        bus.req = '0;
        bus.val = '0;
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1;

        // Reset defaults and quiet idle.
        chk("rst_dec_x", 32'(bus.dec_x), 0);
        chk("rst_h0", 32'(bus.disp_h0), 0);
        chk("rst_h1", 32'(bus.disp_h1), 0);
        chk("rst_ch", 32'(bus.disp_ch), 0);
        chk("rst_valid", 32'(bus.disp_valid), 0);
        chk("rst_ack", 32'(bus.ack), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("idle_busy", 32'(bus.busy), 0);
            chk("idle_valid", 32'(bus.disp_valid), 0);
        end
        chk("idle_h0", 32'(bus.disp_h0), 0);

        // Single request: ch2 value 12.
        bus.val = 16'h0C00;
        bus.req = 4'b0100;
        run_service(4'b0000, 16'h0C00, och, oh0, oh1);
        chk("single_ch", och, 2);
        chk("single_h1", 32'(oh1), 32'(7'b0000110));
        chk("single_h0", 32'(oh0), 32'(7'b1011011));

        // Reset during DRIVE aborts the service; ptr returns to 0.
        bus.val = 16'h7004;
        bus.req = 4'b1001;
        @(posedge clk);
        @(negedge clk);
        chk("abort_dec_x", 32'(bus.dec_x), 7);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_dec_x0", 32'(bus.dec_x), 0);
        chk("abort_h0", 32'(bus.disp_h0), 0);
        chk("abort_h1", 32'(bus.disp_h1), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_ack", 32'(bus.ack), 0);
            chk("abort_valid", 32'(bus.disp_valid), 0);
        end
        m_ptr = 0;
        rst_n = 1'b1;
        run_service(4'b0000, 16'h7004, och, oh0, oh1);
        chk("abort_regrant_ch0", och, 0);

        // Round robin with all four requesting continuously.
        do_reset();
        bus.val = 16'hF905;
        bus.req = 4'b1111;
        rr_exp  = '{0, 1, 2, 3, 0};
        prev    = 0;
        for (int i = 0; i < 5; i++) begin
            run_service(4'b1111, 16'hF905, och, oh0, oh1);
            chk("rr_order", och, rr_exp[i]);
            if (i > 0) chk("rr_spacing", vcyc - prev, HOLD + 3);
            prev = vcyc;
            if (i == 0) begin
                chk("rr_ch0_h0", 32'(oh0), 32'(7'b1101101));
                chk("rr_ch0_h1", 32'(oh1), 32'(7'b0111111));
            end
            if (i == 3) begin
                chk("rr_ch3_h1", 32'(oh1), 32'(7'b0000110));
                chk("rr_ch3_h0", 32'(oh0), 32'(7'b1101101));
            end
        end

        // Pointer wrap: after ch3, ch0 comes before ch3 again.
        bus.req = 4'b1000;
        run_service(4'b1000, 16'hF905, och, oh0, oh1);
        chk("wrap_first_ch3", och, 3);
        bus.req = 4'b1001;
        run_service(4'b1001, 16'hF905, och, oh0, oh1);
        chk("wrap_then_ch0", och, 0);
        run_service(4'b0000, 16'hF905, och, oh0, oh1);
        chk("wrap_then_ch3", och, 3);

        // Late val change and req drop after the grant.
        bus.val = 16'h0030;
        bus.req = 4'b0010;
        run_service(4'b0000, 16'h0070, och, oh0, oh1);
        chk("late_ch", och, 1);
        chk("late_h0", 32'(oh0), 32'(7'b1001111));

        // Randomized requests, values and post-grant disturbances.
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.req = '0;
                repeat ($urandom_range(1, 5)) begin
                    @(negedge clk);
                    chk("rand_idle_busy", 32'(bus.busy), 0);
                end
            end
            bus.req = 4'($urandom_range(1, 15));
            bus.val = 16'($urandom);
            run_service(4'($urandom_range(0, 15)), 16'($urandom), och, oh0, oh1);
        end

        mon_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
